// File: rtl/ls_ex_queued_pkg.sv
// Shared definitions for the queued load/store execution unit:
// op codes, access sizes, FSM states and small op-decode helpers.
package ls_ex_queued_pkg;

    localparam int LS_OP_W = 4;

    localparam logic [LS_OP_W-1:0] LS_OP_NOP = 4'd0;
    localparam logic [LS_OP_W-1:0] LS_OP_LB  = 4'd1;
    localparam logic [LS_OP_W-1:0] LS_OP_LH  = 4'd2;
    localparam logic [LS_OP_W-1:0] LS_OP_LW  = 4'd3;
    localparam logic [LS_OP_W-1:0] LS_OP_LBU = 4'd4;
    localparam logic [LS_OP_W-1:0] LS_OP_LHU = 4'd5;
    localparam logic [LS_OP_W-1:0] LS_OP_SB  = 4'd6;
    localparam logic [LS_OP_W-1:0] LS_OP_SH  = 4'd7;
    localparam logic [LS_OP_W-1:0] LS_OP_SW  = 4'd8;

    localparam logic [2:0] LS_SIZE_B = 3'd1;
    localparam logic [2:0] LS_SIZE_H = 3'd2;
    localparam logic [2:0] LS_SIZE_W = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } ls_state_e;

    function automatic logic ls_is_load(input logic [LS_OP_W-1:0] op);
        return (op >= LS_OP_LB) && (op <= LS_OP_LHU);
    endfunction

    function automatic logic [2:0] ls_size(input logic [LS_OP_W-1:0] op);
        case (op)
            LS_OP_LB, LS_OP_LBU, LS_OP_SB: return LS_SIZE_B;
            LS_OP_LH, LS_OP_LHU, LS_OP_SH: return LS_SIZE_H;
            LS_OP_LW, LS_OP_SW:            return LS_SIZE_W;
            default:                       return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ls_ex_queued_if.sv
// Bundle of LSB-side, memory-controller-side and CDB-side signals of the
// load/store unit; slave is the unit's view, master the environment's view.
interface ls_ex_queued_if
    import ls_ex_queued_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic               rdy;
    logic               flush;

    logic               in_valid;
    logic [LS_OP_W-1:0] in_op;
    logic [XLEN-1:0]    in_addr;
    logic [XLEN-1:0]    in_data;
    logic [TAG_W-1:0]   in_tag;
    logic               in_ready;

    logic               mc_req;
    logic [XLEN-1:0]    mc_addr;
    logic [XLEN-1:0]    mc_wdata;
    logic               mc_we;
    logic [2:0]         mc_size;
    logic               mc_done;
    logic [XLEN-1:0]    mc_rdata;

    logic               cdb_valid;
    logic [TAG_W-1:0]   cdb_tag;
    logic [XLEN-1:0]    cdb_value;

    modport slave (
        input  rdy, flush, in_valid, in_op, in_addr, in_data, in_tag, mc_done, mc_rdata,
        output in_ready, mc_req, mc_addr, mc_wdata, mc_we, mc_size,
               cdb_valid, cdb_tag, cdb_value
    );

    modport master (
        output rdy, flush, in_valid, in_op, in_addr, in_data, in_tag, mc_done, mc_rdata,
        input  in_ready, mc_req, mc_addr, mc_wdata, mc_we, mc_size,
               cdb_valid, cdb_tag, cdb_value
    );

endinterface

// File: rtl/ls_ex_queued_req_fifo.sv
// In-order request FIFO of memory ops; each entry carries an alive bit so a
// flush can bulk-kill queued loads while stores stay eligible for issue.
module ls_ex_queued_req_fifo
    import ls_ex_queued_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic                     i_push,
    input  logic [LS_OP_W-1:0]       i_op,
    input  logic [XLEN-1:0]          i_addr,
    input  logic [XLEN-1:0]          i_data,
    input  logic [TAG_W-1:0]         i_tag,
    input  logic                     i_pop,
    input  logic                     i_kill_loads,
    output logic [LS_OP_W-1:0]       o_op,
    output logic [XLEN-1:0]          o_addr,
    output logic [XLEN-1:0]          o_data,
    output logic [TAG_W-1:0]         o_tag,
    output logic                     o_alive,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [LS_OP_W-1:0] r_op   [DEPTH];
    logic [XLEN-1:0]    r_addr [DEPTH];
    logic [XLEN-1:0]    r_data [DEPTH];
    logic [TAG_W-1:0]   r_tag  [DEPTH];
    logic [DEPTH-1:0]   r_alive;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_alive  <= '0;
        end else if (i_en) begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_loads && ls_is_load(r_op[i])) r_alive[i] <= 1'b0;
            end
            // A push during a kill is always a store, so it lands alive.
            if (i_push) r_alive[r_wr_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_en && i_push) begin
            r_op[r_wr_ptr]   <= i_op;
            r_addr[r_wr_ptr] <= i_addr;
            r_data[r_wr_ptr] <= i_data;
            r_tag[r_wr_ptr]  <= i_tag;
        end
    end

    assign o_op    = r_op[r_rd_ptr];
    assign o_addr  = r_addr[r_rd_ptr];
    assign o_data  = r_data[r_rd_ptr];
    assign o_tag   = r_tag[r_rd_ptr];
    assign o_alive = r_alive[r_rd_ptr] && (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/ls_ex_queued.sv
// Queued load/store execution unit: buffers ops, issues them one at a time to
// the memory controller, extends load data and broadcasts it on the CDB.
module ls_ex_queued
    import ls_ex_queued_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
)
(
    input  logic          clk,
    input  logic          rst,
    ls_ex_queued_if.slave bus
);

    localparam int               CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    ls_state_e          r_state;
    ls_state_e          w_state_nxt;

    logic               w_in_ready;
    logic               w_acc;
    logic               w_push;
    logic               w_pop;
    logic               w_issue_head;
    logic               w_bypass;
    logic               w_issue;
    logic               w_cdb_fire;

    logic [LS_OP_W-1:0] w_head_op;
    logic [XLEN-1:0]    w_head_addr;
    logic [XLEN-1:0]    w_head_data;
    logic [TAG_W-1:0]   w_head_tag;
    logic               w_head_alive;
    logic [CNT_W-1:0]   w_count;

    logic [LS_OP_W-1:0] w_sel_op;
    logic [XLEN-1:0]    w_sel_addr;
    logic [XLEN-1:0]    w_sel_data;
    logic [TAG_W-1:0]   w_sel_tag;

    logic [LS_OP_W-1:0] r_cur_op;
    logic [TAG_W-1:0]   r_cur_tag;
    logic [XLEN-1:0]    r_mc_addr;
    logic [XLEN-1:0]    r_mc_wdata;
    logic               r_mc_we;
    logic [2:0]         r_mc_size;
    logic               r_cdb_valid;
    logic [TAG_W-1:0]   r_cdb_tag;
    logic [XLEN-1:0]    r_cdb_value;

    function automatic logic [XLEN-1:0] f_extend(input logic [LS_OP_W-1:0] op,
                                                 input logic [XLEN-1:0]    d);
        case (op)
            LS_OP_LB:  return {{(XLEN-8){d[7]}},   d[7:0]};
            LS_OP_LH:  return {{(XLEN-16){d[15]}}, d[15:0]};
            LS_OP_LBU: return {{(XLEN-8){1'b0}},   d[7:0]};
            LS_OP_LHU: return {{(XLEN-16){1'b0}},  d[15:0]};
            default:   return d;
        endcase
    endfunction

    ls_ex_queued_req_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_en         (bus.rdy),
        .i_push       (w_push),
        .i_op         (bus.in_op),
        .i_addr       (bus.in_addr),
        .i_data       (bus.in_data),
        .i_tag        (bus.in_tag),
        .i_pop        (w_pop),
        .i_kill_loads (bus.flush),
        .o_op         (w_head_op),
        .o_addr       (w_head_addr),
        .o_data       (w_head_data),
        .o_tag        (w_head_tag),
        .o_alive      (w_head_alive),
        .o_count      (w_count)
    );

    assign w_in_ready = bus.rdy && (w_count != FULL_CNT);
    // Loads presented in a flush cycle are speculative and are refused.
    assign w_acc      = bus.in_valid && w_in_ready && (bus.in_op != LS_OP_NOP) &&
                        !(bus.flush && ls_is_load(bus.in_op));

    always_ff @(posedge clk) begin
        if (rst)          r_state <= ST_IDLE;
        else if (bus.rdy) r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_issue_head = 1'b0;
        w_bypass     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_count != '0) begin
                    w_pop = 1'b1;
                    if (w_head_alive && !(bus.flush && ls_is_load(w_head_op))) begin
                        w_issue_head = 1'b1;
                        w_state_nxt  = ST_REQ;
                    end
                end else if (w_acc) begin
                    // Empty queue: issue straight from the input to save a cycle.
                    w_bypass    = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_state_nxt = (bus.flush && ls_is_load(r_cur_op)) ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mc_done)                                 w_state_nxt = ST_IDLE;
                else if (bus.flush && ls_is_load(r_cur_op))      w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.mc_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_push     = w_acc && !w_bypass;
    assign w_issue    = w_issue_head || w_bypass;
    assign w_cdb_fire = (r_state == ST_WAIT) && bus.mc_done && ls_is_load(r_cur_op) &&
                        !bus.flush;
    assign w_sel_op   = w_bypass ? bus.in_op   : w_head_op;
    assign w_sel_addr = w_bypass ? bus.in_addr : w_head_addr;
    assign w_sel_data = w_bypass ? bus.in_data : w_head_data;
    assign w_sel_tag  = w_bypass ? bus.in_tag  : w_head_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_op    <= LS_OP_NOP;
            r_cur_tag   <= '0;
            r_mc_addr   <= '0;
            r_mc_wdata  <= '0;
            r_mc_we     <= 1'b0;
            r_mc_size   <= 3'd0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_value <= '0;
        end else if (bus.rdy) begin
            r_cdb_valid <= w_cdb_fire;
            if (w_issue) begin
                r_cur_op   <= w_sel_op;
                r_cur_tag  <= w_sel_tag;
                r_mc_addr  <= w_sel_addr;
                r_mc_wdata <= w_sel_data;
                r_mc_we    <= !ls_is_load(w_sel_op);
                r_mc_size  <= ls_size(w_sel_op);
            end
            if (w_cdb_fire) begin
                r_cdb_tag   <= r_cur_tag;
                r_cdb_value <= f_extend(r_cur_op, bus.mc_rdata);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mc_req    = (r_state == ST_REQ) && bus.rdy;
    assign bus.mc_addr   = r_mc_addr;
    assign bus.mc_wdata  = r_mc_wdata;
    assign bus.mc_we     = r_mc_we;
    assign bus.mc_size   = r_mc_size;
    assign bus.cdb_valid = r_cdb_valid && bus.rdy;
    assign bus.cdb_tag   = r_cdb_tag;
    assign bus.cdb_value = r_cdb_value;

endmodule

// File: tb/tb_ls_ex_queued.sv
// Scoreboard bench for ls_ex_queued: stimulus queues expected MC requests and
// CDB results; a monitor pops and compares as the unit presents them.
module tb_ls_ex_queued;
    import ls_ex_queued_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ls_ex_queued_if #(.XLEN(32), .TAG_W(4)) bus ();

    ls_ex_queued #(.XLEN(32), .DEPTH(4), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [67:0] exp_mc_q  [$];
    logic [35:0] exp_cdb_q [$];
    logic [31:0] rdata_q   [$];

    int   mc_lat   = 3;
    logic mc_stall = 1'b0;
    int   lat_cnt  = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_mc(input logic [31:0] a, input logic we, input logic [2:0] sz,
                          input logic [31:0] wd);
        exp_mc_q.push_back({a, we, sz, (we ? wd : 32'h0)});
    endtask

    task automatic exp_cdb(input logic [3:0] tag, input logic [31:0] val);
        exp_cdb_q.push_back({tag, val});
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] tag, input logic fl);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_addr  = addr;
        bus.in_data  = data;
        bus.in_tag   = tag;
        bus.flush    = fl;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_op    = LS_OP_NOP;
        bus.flush    = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tagname);
        chk({tagname, "_mc_req"},    bus.mc_req,    0);
        chk({tagname, "_mc_we"},     bus.mc_we,     0);
        chk({tagname, "_mc_size"},   bus.mc_size,   0);
        chk({tagname, "_mc_addr"},   bus.mc_addr,   0);
        chk({tagname, "_mc_wdata"},  bus.mc_wdata,  0);
        chk({tagname, "_cdb_valid"}, bus.cdb_valid, 0);
        chk({tagname, "_cdb_tag"},   bus.cdb_tag,   0);
        chk({tagname, "_cdb_value"}, bus.cdb_value, 0);
        chk({tagname, "_in_ready"},  bus.in_ready,  1);
    endtask

    // Memory controller model: completes each request mc_lat cycles later.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            bus.mc_done = 1'b0;
            if (rst) begin
                lat_cnt = 0;
            end else begin
                if (lat_cnt > 0 && !mc_stall) begin
                    lat_cnt--;
                    if (lat_cnt == 0) begin
                        bus.mc_done  = 1'b1;
                        bus.mc_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hA5A5A5A5;
                    end
                end
                if (bus.mc_req) begin
                    chk("req_while_mc_busy", (lat_cnt > 0), 0);
                    lat_cnt = mc_lat;
                    if (bus.mc_we) rdata_q.push_front(32'h0);
                end
            end
        end
    end

    // Monitor: compares every presented MC request and CDB result.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.mc_req) begin
                if (exp_mc_q.size() == 0) begin
                    chk("mc_req_unexpected", {bus.mc_addr, bus.mc_we, bus.mc_size}, 0);
                end else begin
                    chk("mc_req", {bus.mc_addr, bus.mc_we, bus.mc_size,
                                   (bus.mc_we ? bus.mc_wdata : 32'h0)}, exp_mc_q.pop_front());
                end
            end
            if (bus.cdb_valid) begin
                chk("cdb_latency", prev_done, 1);
                if (exp_cdb_q.size() == 0) begin
                    chk("cdb_unexpected", {bus.cdb_tag, bus.cdb_value}, 0);
                end else begin
                    chk("cdb", {bus.cdb_tag, bus.cdb_value}, exp_cdb_q.pop_front());
                end
            end
            prev_done = bus.mc_done;
        end
    end

    initial begin
        bus.rdy      = 1'b1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = LS_OP_NOP;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.in_tag   = '0;
        bus.mc_done  = 1'b0;
        bus.mc_rdata = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        chk_reset_outputs("reset");

        // 1: LW, 3-cycle MC latency, request one cycle after acceptance
        mc_lat = 3;
        exp_mc(32'h100, 1'b0, 3'd4, 32'h0);
        rdata_q.push_back(32'hDEADBEEF);
        exp_cdb(4'd5, 32'hDEADBEEF);
        send(LS_OP_LW, 32'h100, 32'h0, 4'd5, 1'b0);
        #3;
        chk("lw_req_latency", bus.mc_req, 1);
        repeat (10) @(negedge clk);

        // 2: byte/half extension
        exp_mc(32'h200, 1'b0, 3'd1, 32'h0); rdata_q.push_back(32'h000000F0); exp_cdb(4'd1, 32'hFFFFFFF0);
        exp_mc(32'h201, 1'b0, 3'd1, 32'h0); rdata_q.push_back(32'h000000F0); exp_cdb(4'd2, 32'h000000F0);
        exp_mc(32'h202, 1'b0, 3'd2, 32'h0); rdata_q.push_back(32'h00008001); exp_cdb(4'd3, 32'hFFFF8001);
        exp_mc(32'h204, 1'b0, 3'd2, 32'h0); rdata_q.push_back(32'h00008001); exp_cdb(4'd4, 32'h00008001);
        send(LS_OP_LB,  32'h200, 32'h0, 4'd1, 1'b0);
        send(LS_OP_LBU, 32'h201, 32'h0, 4'd2, 1'b0);
        send(LS_OP_LH,  32'h202, 32'h0, 4'd3, 1'b0);
        send(LS_OP_LHU, 32'h204, 32'h0, 4'd4, 1'b0);
        repeat (40) @(negedge clk);

        // 3: fill the queue behind a stalled store
        mc_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_mc(32'h300 + 32'(4 * i), 1'b1, 3'd4, 32'h11111111 * 32'(i + 1));
            send(LS_OP_SW, 32'h300 + 32'(4 * i), 32'h11111111 * 32'(i + 1), 4'(i), 1'b0);
            #3;
            chk("fill_in_ready", bus.in_ready, (i < 4) ? 1 : 0);
        end
        send(LS_OP_SW, 32'h3F0, 32'hBADBAD00, 4'd9, 1'b0);
        #3;
        chk("full_in_ready_held", bus.in_ready, 0);
        mc_stall = 1'b0;
        repeat (45) @(negedge clk);

        // 4: flush while SB in flight kills queued loads, keeps stores
        mc_stall = 1'b1;
        exp_mc(32'h400, 1'b1, 3'd1, 32'h123456AB);
        exp_mc(32'h408, 1'b1, 3'd2, 32'h0000BEEF);
        send(LS_OP_SB, 32'h400, 32'h123456AB, 4'd1, 1'b0);
        send(LS_OP_LW, 32'h404, 32'h0,        4'd2, 1'b0);
        send(LS_OP_SH, 32'h408, 32'h0000BEEF, 4'd3, 1'b0);
        send(LS_OP_LH, 32'h40C, 32'h0,        4'd4, 1'b0);
        send(LS_OP_LW, 32'h410, 32'h0,        4'd5, 1'b1);
        #3;
        chk("flush_load_refused_ready", bus.in_ready, 1);
        mc_stall = 1'b0;
        repeat (30) @(negedge clk);

        // 5: flush during an LW in WAIT drains it; store taken in the flush cycle
        exp_mc(32'h500, 1'b0, 3'd4, 32'h0);
        rdata_q.push_back(32'h12345678);
        exp_mc(32'h504, 1'b1, 3'd4, 32'h55AA55AA);
        send(LS_OP_LW, 32'h500, 32'h0,        4'd7, 1'b0);
        send(LS_OP_SW, 32'h504, 32'h55AA55AA, 4'd8, 1'b1);
        repeat (20) @(negedge clk);

        // 6: rdy low mid-WAIT freezes everything, then reset clears it
        mc_stall = 1'b1;
        exp_mc(32'h600, 1'b0, 3'd4, 32'h0);
        send(LS_OP_LW, 32'h600, 32'h0, 4'd9, 1'b0);
        repeat (2) @(negedge clk);
        bus.rdy      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = LS_OP_SW;
        bus.in_addr  = 32'h6F0;
        bus.in_data  = 32'hFFFF0000;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("rdy_low_mc_req",    bus.mc_req,    0);
            chk("rdy_low_cdb_valid", bus.cdb_valid, 0);
            chk("rdy_low_in_ready",  bus.in_ready,  0);
            chk("rdy_low_mc_addr",   bus.mc_addr,   32'h600);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_op    = LS_OP_NOP;
        bus.rdy      = 1'b1;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk_reset_outputs("rst_mid_txn");
        mc_stall = 1'b0;
        rdata_q.delete();
        repeat (2) @(negedge clk);

        // 7: unit works again after reset; positive byte stays positive
        exp_mc(32'h700, 1'b0, 3'd1, 32'h0);
        rdata_q.push_back(32'hABCDEF7F);
        exp_cdb(4'd10, 32'h0000007F);
        send(LS_OP_LB, 32'h700, 32'h0, 4'd10, 1'b0);
        repeat (12) @(negedge clk);

        chk("mc_queue_drained",  exp_mc_q.size(),  0);
        chk("cdb_queue_drained", exp_cdb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
